// File: rtl/muldiv_iter_pkg.sv
// rtl/muldiv_iter_pkg.sv - op and FSM state encodings for the iterative mul/div unit
package muldiv_iter_pkg;

  typedef enum logic [1:0] {
    MULDIV_OP_MUL  = 2'b00,
    MULDIV_OP_IMUL = 2'b01,
    MULDIV_OP_DIV  = 2'b10,
    MULDIV_OP_IDIV = 2'b11
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input muldiv_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring-divide step
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Divide keeps partial remainder < divisor, so trial - divisor always fits WIDTH bits.
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
    trial = acc_i[2*WIDTH-1:WIDTH-1];
    fits  = trial >= {1'b0, opnd_i};
    diff  = trial[WIDTH-1:0] - opnd_i;
    if (is_div_i) begin
      acc_o = {(fits ? diff : trial[WIDTH-1:0]), acc_i[WIDTH-2:0], fits};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative MUL/IMUL/DIV/IDIV unit, one result bit per cycle
module muldiv_iter
  import muldiv_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opnd_hi,
  input  logic [WIDTH-1:0] opnd_lo,
  input  logic [WIDTH-1:0] opnd_src,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             cf_of,
  output logic             div_fault
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  muldiv_state_e    state_q;
  muldiv_op_e       op_q;
  logic [WIDTH-1:0] hi_q, lo_q, src_q, opnd_q;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q;
  logic             neg_main_q, neg_rem_q, ovf_q;
  logic             out_valid_q, cf_of_q, div_fault_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;

  logic             is_div, is_sgn, dvd_neg, lo_neg, src_neg, prep_fault;
  logic [W2-1:0]    dvd_mag, prod;
  logic [WIDTH-1:0] lo_mag, src_mag, quo, rem;
  logic             fix_fault, fix_cf;

  always_comb begin
    is_div     = op_is_div(op_q);
    is_sgn     = op_is_signed(op_q);
    dvd_neg    = is_sgn & hi_q[WIDTH-1];
    lo_neg     = is_sgn & lo_q[WIDTH-1];
    src_neg    = is_sgn & src_q[WIDTH-1];
    dvd_mag    = dvd_neg ? -{hi_q, lo_q} : {hi_q, lo_q};
    lo_mag     = lo_neg ? -lo_q : lo_q;
    src_mag    = src_neg ? -src_q : src_q;
    prep_fault = is_div & ((src_q == '0) | (~is_sgn & (hi_q >= src_q)));
    prod       = neg_main_q ? -acc_q : acc_q;
    quo        = neg_main_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem        = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    // Magnitude 2^(WIDTH-1) is only representable as a negative quotient.
    fix_fault  = is_div & is_sgn &
                 (ovf_q | (acc_q[WIDTH-1] & (~neg_main_q | (acc_q[WIDTH-2:0] != '0))));
    fix_cf     = is_sgn ? (prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                        : (prod[W2-1:WIDTH] != '0);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= MULDIV_OP_MUL;
      hi_q        <= '0;
      lo_q        <= '0;
      src_q       <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_main_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      cf_of_q     <= 1'b0;
      div_fault_q <= 1'b0;
    end else if (kill) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          op_q    <= muldiv_op_e'(op);
          hi_q    <= opnd_hi;
          lo_q    <= opnd_lo;
          src_q   <= opnd_src;
          state_q <= ST_PREP;
        end
        ST_PREP: if (prep_fault) begin
          res_lo_q    <= lo_q;
          res_hi_q    <= hi_q;
          cf_of_q     <= 1'b0;
          div_fault_q <= 1'b1;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end else begin
          acc_q      <= is_div ? dvd_mag : {{WIDTH{1'b0}}, src_mag};
          opnd_q     <= is_div ? src_mag : lo_mag;
          neg_main_q <= is_div ? (dvd_neg ^ src_neg) : (lo_neg ^ src_neg);
          neg_rem_q  <= dvd_neg;
          // A high half not below the divisor means the quotient cannot fit at all.
          ovf_q      <= is_div & is_sgn & (dvd_mag[W2-1:WIDTH] >= src_mag);
          cnt_q      <= '0;
          state_q    <= ST_RUN;
        end
        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div) begin
            res_lo_q    <= fix_fault ? lo_q : quo;
            res_hi_q    <= fix_fault ? hi_q : rem;
            cf_of_q     <= 1'b0;
            div_fault_q <= fix_fault;
          end else begin
            res_lo_q    <= prod[WIDTH-1:0];
            res_hi_q    <= prod[W2-1:WIDTH];
            cf_of_q     <= fix_cf;
            div_fault_q <= 1'b0;
          end
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign res_lo    = res_lo_q;
  assign res_hi    = res_hi_q;
  assign cf_of     = cf_of_q;
  assign div_fault = div_fault_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - self-checking bench for muldiv_iter (WIDTH=32 and WIDTH=8 instances)
module tb_muldiv_iter;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] hi, lo, src;
    logic [31:0] e_lo, e_hi;
    logic        e_cf, e_fault;
    int          lat;
  } vec_t;

  localparam longint QMAX   = 64'sh0000_0000_7FFF_FFFF;
  localparam longint QMIN   = -64'sh0000_0000_8000_0000;
  localparam longint DMIN64 = 64'sh8000_0000_0000_0000;

  logic        clk, rst;
  logic        in_valid, in_ready, kill, out_valid, out_ready, cf_of, div_fault;
  logic [1:0]  op;
  logic [31:0] opnd_hi, opnd_lo, opnd_src, res_lo, res_hi;

  logic        in_valid8, in_ready8, kill8, out_valid8, out_ready8, cf_of8, div_fault8;
  logic [1:0]  op8;
  logic [7:0]  opnd_hi8, opnd_lo8, opnd_src8, res_lo8, res_hi8;

  int   n_run, n_fail;
  vec_t tbl[14];
  vec_t sb[$];

  muldiv_iter #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .opnd_hi(opnd_hi), .opnd_lo(opnd_lo), .opnd_src(opnd_src), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .res_lo(res_lo), .res_hi(res_hi),
    .cf_of(cf_of), .div_fault(div_fault)
  );

  muldiv_iter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .opnd_hi(opnd_hi8), .opnd_lo(opnd_lo8), .opnd_src(opnd_src8), .kill(kill8),
    .out_valid(out_valid8), .out_ready(out_ready8), .res_lo(res_lo8), .res_hi(res_hi8),
    .cf_of(cf_of8), .div_fault(div_fault8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [1:0] o, input logic [31:0] h, l, s);
    vec_t v;
    logic [63:0] p;
    longint d, sv, q, r;
    v.op = o; v.hi = h; v.lo = l; v.src = s;
    v.e_lo = '0; v.e_hi = '0; v.e_cf = 1'b0; v.e_fault = 1'b0; v.lat = 34;
    q = 0; r = 0;
    case (o)
      2'd0: begin
        p = {32'b0, l} * {32'b0, s};
        v.e_lo = p[31:0]; v.e_hi = p[63:32];
        v.e_cf = (v.e_hi != 0);
      end
      2'd1: begin
        d = longint'($signed(l)); sv = longint'($signed(s));
        p = d * sv;
        v.e_lo = p[31:0]; v.e_hi = p[63:32];
        v.e_cf = (v.e_hi != {32{v.e_lo[31]}});
      end
      2'd2: begin
        if (s == 0 || h >= s) begin
          v.e_fault = 1'b1; v.lat = 1;
        end else begin
          p = {h, l};
          v.e_lo = 32'(p / {32'b0, s});
          v.e_hi = 32'(p % {32'b0, s});
        end
      end
      default: begin
        if (s == 0) begin
          v.e_fault = 1'b1; v.lat = 1;
        end else begin
          d = $signed({h, l}); sv = longint'($signed(s));
          if (sv == -1) begin
            if (d == DMIN64) v.e_fault = 1'b1;
            else q = -d;
          end else begin
            q = d / sv; r = d % sv;
          end
          if (!v.e_fault && (q > QMAX || q < QMIN)) v.e_fault = 1'b1;
          if (!v.e_fault) begin
            v.e_lo = q[31:0]; v.e_hi = r[31:0];
          end
        end
      end
    endcase
    if (v.e_fault) begin
      v.e_lo = l; v.e_hi = h;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    op = v.op; opnd_hi = v.hi; opnd_lo = v.lo; opnd_src = v.src; in_valid = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("res_lo", res_lo, e.e_lo);
    chk("res_hi", res_hi, e.e_hi);
    chk("cf_of", cf_of, e.e_cf);
    chk("div_fault", div_fault, e.e_fault);
    chk("in_ready_in_done", in_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("released", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int seen, cyc;
    logic [1:0]  ro;
    logic [31:0] rh, rl, rs;
    logic [15:0] hold;

    n_run = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    op = '0; opnd_hi = '0; opnd_lo = '0; opnd_src = '0;
    in_valid8 = 1'b0; kill8 = 1'b0; out_ready8 = 1'b0;
    op8 = '0; opnd_hi8 = '0; opnd_lo8 = '0; opnd_src8 = '0;

    tbl[0]  = '{2'd0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 34};
    tbl[1]  = '{2'd1, 32'h0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
    tbl[2]  = '{2'd2, 32'h0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34};
    tbl[3]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 34};
    tbl[4]  = '{2'd2, 32'h12, 32'h34, 32'h0, 32'h34, 32'h12, 1'b0, 1'b1, 1};
    tbl[5]  = '{2'd3, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 34};
    tbl[6]  = '{2'd2, 32'h5, 32'h0, 32'h5, 32'h0, 32'h5, 1'b0, 1'b1, 1};
    tbl[7]  = '{2'd0, 32'h0, 32'h10000, 32'h10000, 32'h0, 32'h1, 1'b1, 1'b0, 34};
    tbl[8]  = '{2'd1, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b1, 1'b0, 34};
    tbl[9]  = '{2'd3, 32'h0, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b0, 34};
    tbl[10] = '{2'd3, 32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h80000000, 32'h0, 1'b0, 1'b0, 34};
    tbl[11] = '{2'd2, 32'hFFFFFFFE, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4, 1'b0, 1'b0, 34};
    tbl[12] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hE, 32'hFFFFFFFE, 1'b0, 1'b0, 34};
    tbl[13] = '{2'd1, 32'h0, 32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h0, 1'b1, 1'b0, 34};

    repeat (3) @(negedge clk);
    chk("reset_flags", {out_valid, cf_of, div_fault}, 3'b000);
    chk("reset_res", {res_hi, res_lo}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1'b1);

    for (int i = 0; i < 14; i++) run_vec(tbl[i]);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      rl = $urandom;
      rs = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 999));
      rh = $urandom;
      if (ro == 2'd2 && rs != 0) rh = $urandom % rs;
      if (ro == 2'd3 && $urandom_range(0, 3) != 0) rh = {32{rl[31]}};
      run_vec(model(ro, rh, rl, rs));
    end

    // WIDTH=8: 200*15 = 3000 = 0x0BB8, held while the consumer stalls
    op8 = 2'd0; opnd_hi8 = 8'h00; opnd_lo8 = 8'hC8; opnd_src8 = 8'h0F; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("w8_latency", cyc, 10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      hold = {res_hi8, res_lo8};
      chk("w8_stall_valid", out_valid8, 1'b1);
      chk("w8_stall_res", {hold, cf_of8, div_fault8}, {16'h0BB8, 1'b1, 1'b0});
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk("w8_released", {out_valid8, in_ready8}, 2'b01);

    // kill in the third RUN cycle
    op = 2'd0; opnd_lo = 32'hFFFFFFFF; opnd_src = 32'h3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_idle", {out_valid, in_ready}, 2'b01);
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    chk("kill_no_result", seen, 0);

    // kill wins over a simultaneous accept
    op = 2'd0; opnd_lo = 32'h3; opnd_src = 32'h5; in_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_beats_accept", in_ready, 1'b1);

    // kill in DONE together with a handshake
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
    chk("kill_done_reached", {out_valid, res_lo}, {1'b1, 32'd15});
    kill = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    kill = 1'b0; out_ready = 1'b0;
    chk("kill_in_done", {out_valid, in_ready}, 2'b01);

    // reset mid-RUN while result registers still hold the previous product
    op = 2'd0; opnd_lo = 32'hFFFFFFFF; opnd_src = 32'hFFFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rst_mid_flags", {out_valid, cf_of, div_fault, in_ready}, 4'b0001);
    chk("rst_mid_res", {res_hi, res_lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1'b1);
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    chk("rst_no_result", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
